// File: rtl/lexington_pkg.sv
// Shared types, defaults and lane helpers for the data-bus router.
// Latency: none, only types and pure combinational functions.
// Backpressure: not applicable.
package lexington_pkg;

    typedef enum logic [1:0] {
        DBUS_BYTE = 2'd0,
        DBUS_HALF = 2'd1,
        DBUS_WORD = 2'd2
    } dbus_size_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } dbus_state_t;

    localparam int DEFAULT_DBUS_TIMEOUT = 255;

    // Any size code other than BYTE/HALF is handled as a word access.
    function automatic logic is_misaligned(input dbus_size_t size, input logic [1:0] a);
        case (size)
            DBUS_BYTE: is_misaligned = 1'b0;
            DBUS_HALF: is_misaligned = a[0];
            default:   is_misaligned = |a;
        endcase
    endfunction

    function automatic logic [3:0] byte_strobe(input dbus_size_t size, input logic [1:0] a);
        case (size)
            DBUS_BYTE: byte_strobe = 4'b0001 << a;
            DBUS_HALF: byte_strobe = 4'b0011 << {a[1], 1'b0};
            default:   byte_strobe = 4'b1111;
        endcase
    endfunction

    // Replicate the LSB-aligned store data onto every lane it may land on.
    function automatic logic [31:0] lane_data(input dbus_size_t size, input logic [31:0] d);
        case (size)
            DBUS_BYTE: lane_data = {4{d[7:0]}};
            DBUS_HALF: lane_data = {2{d[15:0]}};
            default:   lane_data = d;
        endcase
    endfunction

endpackage

// File: rtl/dbus_decode.sv
// Region decoder: address -> hit, one-hot select, slave index, word offset.
// Latency: purely combinational.
// Backpressure: none; overlapping regions resolve to the lowest index.
module dbus_decode #(
    parameter int                    NUM_SLV       = 4,
    parameter logic [NUM_SLV*32-1:0] SLV_BASE      = {NUM_SLV{32'h0}},
    parameter logic [NUM_SLV*8-1:0]  SLV_SIZE_LOG2 = {NUM_SLV{8'd12}},
    parameter int                    IDX_W         = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
    input  logic [31:0]        i_addr,
    output logic               o_hit,
    output logic [NUM_SLV-1:0] o_sel,
    output logic [IDX_W-1:0]   o_idx,
    output logic [29:0]        o_offset
);

    logic [31:0] w_mask;

    // Scan from the top index down so the lowest matching region is written last.
    always_comb begin
        o_hit    = 1'b0;
        o_sel    = '0;
        o_idx    = '0;
        o_offset = '0;
        w_mask   = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            w_mask = (32'h1 << SLV_SIZE_LOG2[i*8 +: 8]) - 32'h1;
            if ((i_addr & ~w_mask) == (SLV_BASE[i*32 +: 32] & ~w_mask)) begin
                o_hit    = 1'b1;
                o_sel    = '0;
                o_sel[i] = 1'b1;
                o_idx    = IDX_W'(i);
                o_offset = i_addr[31:2] & w_mask[31:2];
            end
        end
    end

endmodule

// File: rtl/dbus_router.sv
// LSU data-bus router: decode, strobes, misalign/access faults, wait tracking.
// Latency: zero-cycle completion when the slave is ready; otherwise held in WAIT.
// Backpressure: slv_busy raises dbus_wait; optional DBUS_TIMEOUT_EN bounds the wait.
module dbus_router
    import lexington_pkg::*;
#(
    parameter int                    NUM_SLV       = 4,
    parameter logic [NUM_SLV*32-1:0] SLV_BASE      = {NUM_SLV{32'h0}},
    parameter logic [NUM_SLV*8-1:0]  SLV_SIZE_LOG2 = {NUM_SLV{8'd12}},
    parameter int                    WAIT_TIMEOUT  = DEFAULT_DBUS_TIMEOUT
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_rd_en,
    input  logic                    i_wr_en,
    input  logic [31:0]             i_addr,
    input  logic [1:0]              i_size,
    input  logic [31:0]             i_wr_data,
    output logic [31:0]             o_rd_data,
    output logic                    o_dbus_wait,
    output logic                    o_dbus_err,
    output logic                    o_data_misaligned,
    output logic                    o_data_access_fault,
    output logic                    o_load_store_n,
    output logic [NUM_SLV-1:0]      o_slv_rd_en,
    output logic [NUM_SLV-1:0]      o_slv_wr_en,
    output logic [29:0]             o_slv_addr,
    input  logic [NUM_SLV*32-1:0]   i_slv_rd_data,
    input  logic [NUM_SLV-1:0]      i_slv_busy,
    input  logic [NUM_SLV-1:0]      i_slv_fault,
    output logic [31:0]             o_wr_data,
    output logic [3:0]              o_wr_strobe
);

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    if (NUM_SLV < 1 || NUM_SLV > 16 || WAIT_TIMEOUT < 1) begin : g_bad_params
        $error("dbus_router: parameter out of range");
    end

    dbus_state_t        r_state;
    logic [IDX_W-1:0]   r_idx;
`ifdef DBUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(WAIT_TIMEOUT + 2);
    logic [CNT_W-1:0]   r_cnt;
`endif

    dbus_size_t         w_size;
    logic               w_req;
    logic               w_misal;
    logic               w_hit;
    logic [NUM_SLV-1:0] w_dec_sel;
    logic [IDX_W-1:0]   w_dec_idx;
    logic [29:0]        w_offset;
    logic [NUM_SLV-1:0] w_lat_sel;
    logic [NUM_SLV-1:0] w_en;
    logic [IDX_W-1:0]   w_cur_idx;
    logic [31:0]        w_rd_word;
    logic               w_wait;
    logic               w_afault;
    logic               w_mis;

    assign w_size  = dbus_size_t'(i_size);
    assign w_req   = i_rd_en | i_wr_en;
    assign w_misal = is_misaligned(w_size, i_addr[1:0]);

    dbus_decode #(
        .NUM_SLV       (NUM_SLV),
        .SLV_BASE      (SLV_BASE),
        .SLV_SIZE_LOG2 (SLV_SIZE_LOG2),
        .IDX_W         (IDX_W)
    ) u_decode (
        .i_addr   (i_addr),
        .o_hit    (w_hit),
        .o_sel    (w_dec_sel),
        .o_idx    (w_dec_idx),
        .o_offset (w_offset)
    );

    // Transaction control: pick the target slave and classify the cycle outcome.
    always_comb begin
        w_en      = '0;
        w_wait    = 1'b0;
        w_afault  = 1'b0;
        w_mis     = 1'b0;
        w_cur_idx = w_dec_idx;
        if (w_req) begin
            if (r_state == IDLE) begin
                if (w_misal) begin
                    w_mis = 1'b1;
                end else if (!w_hit) begin
                    w_afault = 1'b1;
                end else begin
                    w_en = w_dec_sel;
                    if (i_slv_fault[w_dec_idx]) begin
                        w_afault = 1'b1;
                    end else if (i_slv_busy[w_dec_idx]) begin
                        w_wait = 1'b1;
                    end
                end
            end else begin
                // Held request: stay on the slave that first stalled us.
                w_cur_idx = r_idx;
                w_en      = w_lat_sel;
                if (i_slv_fault[r_idx]) begin
                    w_afault = 1'b1;
                end else if (i_slv_busy[r_idx]) begin
`ifdef DBUS_TIMEOUT_EN
                    if (r_cnt == CNT_W'(WAIT_TIMEOUT)) begin
                        w_en     = '0;
                        w_afault = 1'b1;
                    end else begin
                        w_wait = 1'b1;
                    end
`else
                    w_wait = 1'b1;
`endif
                end
            end
        end
    end

    // Latched-slave one-hot and read-data mux for the slave currently addressed.
    always_comb begin
        w_lat_sel = '0;
        w_rd_word = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_lat_sel[i] = 1'b1;
            end
            if (w_cur_idx == IDX_W'(i)) begin
                w_rd_word = i_slv_rd_data[i*32 +: 32];
            end
        end
    end

    assign o_slv_rd_en         = w_en & {NUM_SLV{~i_wr_en}};
    assign o_slv_wr_en         = w_en & {NUM_SLV{i_wr_en}};
    assign o_slv_addr          = (|w_en) ? w_offset : '0;
    assign o_rd_data           = (|o_slv_rd_en) ? w_rd_word : '0;
    assign o_wr_strobe         = (|o_slv_wr_en) ? byte_strobe(w_size, i_addr[1:0]) : '0;
    assign o_wr_data           = (|o_slv_wr_en) ? lane_data(w_size, i_wr_data) : '0;
    assign o_dbus_wait         = w_wait;
    assign o_data_misaligned   = w_mis;
    assign o_data_access_fault = w_afault;
    assign o_dbus_err          = w_mis | w_afault;
    assign o_load_store_n      = (w_mis | w_afault) & ~i_wr_en;

    // State, latched slave index and wait counter; any non-wait cycle in WAIT ends it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
`ifdef DBUS_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else if (r_state == IDLE) begin
            if (w_wait) begin
                r_state <= WAIT;
                r_idx   <= w_dec_idx;
`ifdef DBUS_TIMEOUT_EN
                r_cnt   <= '0;
`endif
            end
        end else begin
            if (!w_wait) begin
                r_state <= IDLE;
            end
`ifdef DBUS_TIMEOUT_EN
            else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_dbus_router.sv
module tb_dbus_router;

    localparam int TO = 8;
    localparam logic [127:0] BASE = {32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [31:0]  SZL  = {8'd28, 8'd20, 8'd12, 8'd16};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rd_en, wr_en;
    logic [31:0]  addr, wdat;
    logic [1:0]   size;
    logic [127:0] srd;
    logic [3:0]   busy, fault;

    logic [31:0]  rd_data, wr_data;
    logic         dbus_wait, dbus_err, mis, af, lsn;
    logic [3:0]   slv_rd_en, slv_wr_en, wr_strobe;
    logic [29:0]  slv_addr;

    dbus_router #(
        .NUM_SLV(4), .SLV_BASE(BASE), .SLV_SIZE_LOG2(SZL), .WAIT_TIMEOUT(TO)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(rd_en), .i_wr_en(wr_en),
        .i_addr(addr), .i_size(size), .i_wr_data(wdat),
        .o_rd_data(rd_data), .o_dbus_wait(dbus_wait), .o_dbus_err(dbus_err),
        .o_data_misaligned(mis), .o_data_access_fault(af), .o_load_store_n(lsn),
        .o_slv_rd_en(slv_rd_en), .o_slv_wr_en(slv_wr_en), .o_slv_addr(slv_addr),
        .i_slv_rd_data(srd), .i_slv_busy(busy), .i_slv_fault(fault),
        .o_wr_data(wr_data), .o_wr_strobe(wr_strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [31:0] rdat;
        bit [31:0] wdat;
        bit [29:0] saddr;
        bit [3:0]  rden;
        bit [3:0]  wren;
        bit [3:0]  strb;
        bit        wt, err, mis, af, lsn;
        int        slv;
    } exp_t;

    bit [31:0] base_a [4] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h1000_0000};
    int        lg     [4] = '{16, 12, 20, 28};

    int    n_cmp = 0;
    int    n_err = 0;
    string phase = "init";
    bit    m_waiting = 1'b0;
    int    m_lat = 0;
    int    m_cnt = 0;
    exp_t  cur_e;

    // Reference: what one cycle should produce from the current request and model state.
    function automatic exp_t model();
        exp_t e;
        int   s;
        bit   go;
        e = '{default: 0};
        e.slv = -1;
        if (!(rd_en || wr_en)) return e;
        if (!m_waiting) begin
            if ((size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0)) begin
                e.mis = 1; e.err = 1; e.lsn = !wr_en;
                return e;
            end
            s = -1;
            for (int i = 3; i >= 0; i--)
                if ((addr >> lg[i]) == (base_a[i] >> lg[i])) s = i;
            if (s < 0) begin
                e.af = 1; e.err = 1; e.lsn = !wr_en;
                return e;
            end
        end else begin
            s = m_lat;
        end
        e.slv = s;
        go = 1;
        if (fault[s]) begin
            e.af = 1;
        end else if (busy[s]) begin
`ifdef DBUS_TIMEOUT_EN
            if (m_waiting && m_cnt == TO) begin e.af = 1; go = 0; end
            else e.wt = 1;
`else
            e.wt = 1;
`endif
        end
        e.err = e.af;
        e.lsn = e.af && !wr_en;
        if (go) begin
            e.saddr = 30'((64'(addr) % (64'd1 << lg[s])) / 4);
            if (wr_en) begin
                e.wren = 4'(1 << s);
                case (size)
                    2'd0:    begin e.strb = 4'(1 << (addr % 4)); e.wdat = 32'(wdat[7:0]) * 32'h0101_0101; end
                    2'd1:    begin e.strb = 4'(3 << (addr % 4)); e.wdat = 32'(wdat[15:0]) * 32'h0001_0001; end
                    default: begin e.strb = 4'hF; e.wdat = wdat; end
                endcase
            end else begin
                e.rden = 4'(1 << s);
                e.rdat = srd[s*32 +: 32];
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
        end
    endtask

    // Sample on the falling edge and compare every output against the model.
    task automatic sample();
        @(negedge clk);
        cur_e = model();
        chk("rd_data",   rd_data,   cur_e.rdat);
        chk("wait",      32'(dbus_wait), 32'(cur_e.wt));
        chk("err",       32'(dbus_err),  32'(cur_e.err));
        chk("misalign",  32'(mis),       32'(cur_e.mis));
        chk("afault",    32'(af),        32'(cur_e.af));
        chk("ld_st_n",   32'(lsn),       32'(cur_e.lsn));
        chk("slv_rd_en", 32'(slv_rd_en), 32'(cur_e.rden));
        chk("slv_wr_en", 32'(slv_wr_en), 32'(cur_e.wren));
        chk("slv_addr",  32'(slv_addr),  32'(cur_e.saddr));
        chk("wr_data",   wr_data,        cur_e.wdat);
        chk("strobe",    32'(wr_strobe), 32'(cur_e.strb));
    endtask

    // Clock edge: advance the model's notion of an outstanding stalled access.
    task automatic adv();
        @(posedge clk);
        if (!rst_n) begin
            m_waiting = 0; m_cnt = 0;
        end else if (!m_waiting) begin
            if (cur_e.wt) begin m_waiting = 1; m_lat = cur_e.slv; m_cnt = 0; end
        end else begin
            if (!cur_e.wt) m_waiting = 0;
            else m_cnt++;
        end
        #1;
    endtask

    task automatic tick();
        sample();
        adv();
    endtask

    task automatic req(input bit r, input bit w, input logic [31:0] a, input logic [1:0] sz);
        rd_en = r; wr_en = w; addr = a; size = sz;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nwait;
        rst_n = 0; rd_en = 0; wr_en = 0; addr = 0; size = 0; wdat = 0;
        busy = 0; fault = 0; srd = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        phase = "reset";
        sample();
        chk("rst_en", 32'(slv_rd_en | slv_wr_en), 32'd0);
        adv();

        phase = "word_rd";
        srd[63:32] = 32'hDEAD_BEEF;
        req(1, 0, 32'h1000_0008, 2'd2);
        sample();
        chk("c_rden", 32'(slv_rd_en), 32'b0010);
        chk("c_saddr", 32'(slv_addr), 32'd2);
        chk("c_rdata", rd_data, 32'hDEAD_BEEF);
        adv();

        phase = "byte_wr";
        wdat = 32'h1234_56AB;
        req(0, 1, 32'h1000_0003, 2'd0);
        sample();
        chk("c_strb", 32'(wr_strobe), 32'b1000);
        chk("c_wdat", wr_data, 32'hABAB_ABAB);
        chk("c_wren", 32'(slv_wr_en), 32'b0010);
        chk("c_wait", 32'(dbus_wait), 32'd0);
        adv();

        phase = "busy3";
        req(1, 0, 32'h1000_0004, 2'd2);
        busy = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("c_wait_hi", 32'(dbus_wait), 32'd1);
            adv();
        end
        busy = 0;
        sample();
        chk("c_done", 32'(dbus_wait), 32'd0);
        chk("c_done_en", 32'(slv_rd_en), 32'b0010);
        adv();
        req(0, 0, 0, 0);
        tick();

        phase = "unmapped";
        req(1, 0, 32'hF000_0000, 2'd2);
        sample();
        chk("c_af", 32'({af, dbus_err, lsn}), 32'b111);
        chk("c_noen", 32'(slv_rd_en | slv_wr_en), 32'd0);
        adv();

        phase = "misalign";
        req(0, 1, 32'h1000_0001, 2'd1);
        sample();
        chk("c_mis", 32'({mis, af, lsn}), 32'b100);
        adv();

        phase = "overlap";
        req(1, 0, 32'h1000_2000, 2'd2);
        sample();
        chk("c_ovl_en", 32'(slv_rd_en), 32'b1000);
        chk("c_ovl_addr", 32'(slv_addr), 32'h800);
        adv();
        req(1, 1, 32'h1000_0010, 2'd2);
        wdat = $urandom;
        tick();

        phase = "slv_fault";
        fault = 4'b0010;
        req(1, 0, 32'h1000_0000, 2'd2);
        tick();
        fault = 0;

        phase = "long_wait";
        busy = 4'b0100;
        req(1, 0, 32'h2000_0100, 2'd2);
        nwait = 0;
        for (int k = 0; k < 130; k++) begin
            sample();
            adv();
            if (!cur_e.wt) break;
            nwait++;
        end
`ifdef DBUS_TIMEOUT_EN
        chk("c_timeout_waits", 32'(nwait), 32'(TO + 1));
`else
        chk("c_no_timeout", 32'(nwait), 32'd130);
`endif
        phase = "drop";
        req(0, 0, 0, 0);
        sample();
        chk("c_drop_en", 32'(slv_rd_en | slv_wr_en), 32'd0);
        chk("c_drop_err", 32'(dbus_err), 32'd0);
        adv();
        busy = 0;

        phase = "rst_wait";
        busy = 4'b0010;
        req(1, 0, 32'h1000_0000, 2'd2);
        tick();
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        req(1, 0, 32'h2000_0000, 2'd2);
        sample();
        chk("c_after_rst", 32'(slv_rd_en), 32'b0100);
        chk("c_after_rst_err", 32'(dbus_err), 32'd0);
        adv();
        req(0, 0, 0, 0);
        busy = 0;
        tick();

        phase = "random";
        for (int c = 0; c < 600; c++) begin
            if (!cur_e.wt) begin
                logic [31:0] a;
                int          op;
                case ($urandom_range(4))
                    0:       a = $urandom_range(32'hFFFF);
                    1:       a = 32'h1000_0000 + $urandom_range(32'hFFF);
                    2:       a = 32'h2000_0000 + $urandom_range(32'hF_FFFF);
                    3:       a = 32'h1000_0000 + $urandom_range(32'h0FFF_FFFF);
                    default: a = 32'hF000_0000 | $urandom;
                endcase
                size = 2'($urandom_range(2));
                if ($urandom_range(3) != 0)
                    a = a & ~((size == 2'd2) ? 32'd3 : (size == 2'd1) ? 32'd1 : 32'd0);
                addr = a;
                op = $urandom_range(3);
                rd_en = op[0];
                wr_en = op[1];
                wdat = $urandom;
            end else if ($urandom_range(15) == 0) begin
                rd_en = 0; wr_en = 0;
            end
            busy  = 4'($urandom) & 4'($urandom);
            fault = ($urandom_range(7) == 0) ? 4'(1 << $urandom_range(3)) : 4'd0;
            srd   = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
